// File: rtl/reg_bus_arb_pkg.sv
// Shared definitions for the register-bus arbiter: FSM encoding and widths.
`timescale 1ns/1ps
package reg_bus_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int RD_CNT_W    = 4;   // holds RD_LAT-1 for RD_LAT up to 15
  localparam int TMOUT_W     = 16;  // width of the grant-wait counter and limit

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

endpackage

// File: rtl/tmout_watch.sv
// Grant-wait watchdog for one master: counts cycles spent waiting for the bus
// and emits a single pulse when the count reaches the configured limit.
`timescale 1ns/1ps
module tmout_watch
  import reg_bus_arb_pkg::*;
(
  input  logic               clks,
  input  logic               reset,
  input  logic               i_req,    // master is requesting
  input  logic               i_owner,  // master's transaction is in flight
  input  logic               i_grant,  // master is being latched this cycle
  input  logic [TMOUT_W-1:0] i_cfg,    // limit; 0 disables
  output logic               o_err
);

  logic [TMOUT_W-1:0] r_cnt;
  logic               r_fired;
  logic               r_err;

  logic               w_wait;
  logic [TMOUT_W-1:0] w_cnt_next;
  logic               w_hit;

  // A grant clears the counter in the same cycle, so it never counts as waiting.
  assign w_wait     = i_req && !i_owner && !i_grant;
  assign w_cnt_next = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  // Equality (not >=) so lowering the limit below the running count stays silent.
  assign w_hit      = w_wait && (i_cfg != '0) && !r_fired && (w_cnt_next == i_cfg);
  assign o_err      = r_err;

  // Wait counter with saturation, fire-once flag and registered error pulse.
  always_ff @(posedge clks) begin
    if (reset) begin
      r_cnt   <= '0;
      r_fired <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_hit;
      if (!i_req || i_grant) begin
        r_cnt   <= '0;
        r_fired <= 1'b0;
      end else if (w_wait) begin
        r_cnt <= w_cnt_next;
        if (w_hit) r_fired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the user-logic register
// bus. One transaction at a time; reads capture data RD_LAT cycles after the
// read strobe; per-master grant-wait watchdogs flag starved requesters.
`timescale 1ns/1ps
module reg_bus_arbiter
  import reg_bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 2
) (
  input  logic                   clks,
  input  logic                   reset,
  input  logic                   m0_req,
  input  logic                   m0_wr,
  input  logic [ADDR_WIDTH-1:0]  m0_addr,
  input  logic [DATA_WIDTH-1:0]  m0_wdata,
  output logic                   m0_ack,
  output logic [DATA_WIDTH-1:0]  m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_wr,
  input  logic [ADDR_WIDTH-1:0]  m1_addr,
  input  logic [DATA_WIDTH-1:0]  m1_wdata,
  output logic                   m1_ack,
  output logic [DATA_WIDTH-1:0]  m1_rdata,
  input  logic [TMOUT_W-1:0]     tmout_cfg,
  output logic [NUM_MASTERS-1:0] tmout_err,
  output logic                   cpu_wr,
  output logic                   cpu_rd,
  output logic [ADDR_WIDTH-1:0]  cpu_wr_addr,
  output logic [DATA_WIDTH-1:0]  cpu_data_in,
  input  logic [DATA_WIDTH-1:0]  cpu_data_out
);

  localparam logic [RD_CNT_W-1:0] RD_LAST = RD_CNT_W'(RD_LAT - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_ptr;      // master that wins a tie
  logic                    r_owner;    // master of the latched transaction
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [RD_CNT_W-1:0]     r_rd_cnt;
  logic [DATA_WIDTH-1:0]   r_m0_rdata;
  logic [DATA_WIDTH-1:0]   r_m1_rdata;

  logic [NUM_MASTERS-1:0]  w_req;
  logic [NUM_MASTERS-1:0]  w_own;
  logic [NUM_MASTERS-1:0]  w_grant;
  logic                    w_start;
  logic                    w_busy;
  logic                    w_sel;
  logic                    w_sel_wr;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic                    w_rd_last;
  logic                    w_cpu_wr;
  logic                    w_cpu_rd;
  logic [NUM_MASTERS-1:0]  w_ack;

  // Request selection: a lone requester wins outright, a tie goes to r_ptr.
  assign w_req       = {m1_req, m0_req};
  assign w_sel       = (m0_req && m1_req) ? r_ptr : m1_req;
  assign w_sel_wr    = w_sel ? m1_wr    : m0_wr;
  assign w_sel_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_sel ? m1_wdata : m0_wdata;

  assign w_start   = (r_state == ST_IDLE) && (|w_req);
  assign w_busy    = (r_state != ST_IDLE);
  assign w_grant   = {w_start && w_sel, w_start && !w_sel};
  assign w_own     = {w_busy && r_owner, w_busy && !r_owner};
  assign w_rd_last = (r_rd_cnt == RD_LAST);

  // FSM state register.
  always_ff @(posedge clks) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of block ordering.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and bus strobes/acks.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_next = r_state;
    w_cpu_wr     = 1'b0;
    w_cpu_rd     = 1'b0;
    w_ack        = '0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = w_sel_wr ? ST_WR : ST_RD;
      ST_WR: begin
        w_cpu_wr     = 1'b1;
        w_state_next = ST_ACK;
      end
      ST_RD: begin
        w_cpu_rd = (r_rd_cnt == '0);
        if (w_rd_last) w_state_next = ST_ACK;
      end
      ST_ACK: begin
        w_ack[r_owner] = 1'b1;
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: latch the winner, count read latency, capture return data,
  // rotate the priority pointer on completion.
  always_ff @(posedge clks) begin
    // NOTE: the bus-facing address/data and rdata registers are reset too,
    // because their reset value of 0 is visible on the outputs.
    if (reset) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_cnt   <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_owner  <= w_sel;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_rd_cnt <= '0;
          end
        end
        ST_WR: begin
          if (r_owner) r_m1_rdata <= '0;
          else         r_m0_rdata <= '0;
        end
        ST_RD: begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (w_rd_last) begin
            if (r_owner) r_m1_rdata <= cpu_data_out;
            else         r_m0_rdata <= cpu_data_out;
          end
        end
        ST_ACK: r_ptr <= ~r_owner;
        default: ;
      endcase
    end
  end

  // One grant-wait watchdog per master.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_watch
    tmout_watch u_watch (
      .clks    (clks),
      .reset   (reset),
      .i_req   (w_req[g]),
      .i_owner (w_own[g]),
      .i_grant (w_grant[g]),
      .i_cfg   (tmout_cfg),
      .o_err   (tmout_err[g])
    );
  end

  assign cpu_wr      = w_cpu_wr;
  assign cpu_rd      = w_cpu_rd;
  assign cpu_wr_addr = r_addr;
  assign cpu_data_in = r_wdata;
  assign m0_ack      = w_ack[0];
  assign m1_ack      = w_ack[1];
  assign m0_rdata    = r_m0_rdata;
  assign m1_rdata    = r_m1_rdata;

endmodule
